// File: rtl/controlador_ataque.sv
// Attack-round controller: accepts shots on a 7x5 grid against a captured enemy map,
// tracks hit/miss masks and counters, and declares victory or defeat.
//
// state   | meaning
// OCIOSO  | idle, waiting for attack mode
// AGUARDA | round active, waiting for a valid fire event
// AVALIA  | evaluating the latched shot
// FIM     | round over, outputs held until attack mode drops
module controlador_ataque #(
    parameter int MAX_TIROS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        modo_ataque,
    input  logic        disparo,
    input  logic [2:0]  coord_linha,
    input  logic [2:0]  coord_coluna,
    input  logic [34:0] mapa,
    output logic [34:0] celulas_atingidas,
    output logic [34:0] celulas_erradas,
    output logic [5:0]  acertos,
    output logic [5:0]  tiros,
    output logic        led_acerto,
    output logic        led_erro,
    output logic        vitoria,
    output logic        derrota,
    output logic [1:0]  estado
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        AGUARDA = 2'd1,
        AVALIA  = 2'd2,
        FIM     = 2'd3
    } estado_t;

    localparam logic [5:0] MAX_T = 6'(MAX_TIROS);

    estado_t     estado_q, estado_d;
    logic [34:0] mapa_q, mapa_d;
    logic [5:0]  total_q, total_d;
    logic [5:0]  idx_q, idx_d;
    logic        disparo_q;
    logic [34:0] ating_q, ating_d;
    logic [34:0] err_q, err_d;
    logic [5:0]  acertos_q, acertos_d;
    logic [5:0]  tiros_q, tiros_d;
    logic        led_ac_q, led_ac_d;
    logic        led_er_q, led_er_d;
    logic        vit_q, vit_d;
    logic        der_q, der_d;

    logic [5:0]  pop;
    logic [5:0]  idx_novo;
    logic [63:0] ocupado;
    logic [63:0] mapa_ext;
    logic        evento;
    logic        coord_ok;
    logic        acerto;
    logic [5:0]  acertos_prox;
    logic [5:0]  tiros_prox;

    always_comb begin
        pop = 6'd0;
        for (int i = 0; i < 35; i++) begin
            pop = pop + {5'd0, mapa[i]};
        end
    end

    // Masks widened to 64 bits so any 6-bit index is in range; illegal coords are gated by coord_ok.
    assign idx_novo     = ({3'd0, coord_linha} * 6'd5) + {3'd0, coord_coluna};
    assign ocupado      = {29'd0, ating_q | err_q};
    assign mapa_ext     = {29'd0, mapa_q};
    assign evento       = disparo & ~disparo_q;
    assign coord_ok     = (coord_linha <= 3'd6) && (coord_coluna <= 3'd4);
    assign acerto       = mapa_ext[idx_q];
    assign acertos_prox = acertos_q + {5'd0, acerto};
    assign tiros_prox   = tiros_q + 6'd1;

    always_comb begin
        estado_d  = estado_q;
        mapa_d    = mapa_q;
        total_d   = total_q;
        idx_d     = idx_q;
        ating_d   = ating_q;
        err_d     = err_q;
        acertos_d = acertos_q;
        tiros_d   = tiros_q;
        led_ac_d  = led_ac_q;
        led_er_d  = led_er_q;
        vit_d     = vit_q;
        der_d     = der_q;

        case (estado_q)
            OCIOSO: begin
                if (modo_ataque) begin
                    estado_d  = AGUARDA;
                    mapa_d    = mapa;
                    total_d   = pop;
                    ating_d   = '0;
                    err_d     = '0;
                    acertos_d = '0;
                    tiros_d   = '0;
                    led_ac_d  = 1'b0;
                    led_er_d  = 1'b0;
                    vit_d     = 1'b0;
                    der_d     = 1'b0;
                end
            end
            AGUARDA: begin
                if (total_q == 6'd0) begin
                    estado_d = FIM;
                    vit_d    = 1'b1;
                end else if (evento && coord_ok && !ocupado[idx_novo]) begin
                    idx_d    = idx_novo;
                    estado_d = AVALIA;
                end
            end
            AVALIA: begin
                tiros_d = tiros_prox;
                if (acerto) begin
                    ating_d   = ating_q | (35'd1 << idx_q);
                    acertos_d = acertos_prox;
                    led_ac_d  = 1'b1;
                    led_er_d  = 1'b0;
                end else begin
                    err_d    = err_q | (35'd1 << idx_q);
                    led_ac_d = 1'b0;
                    led_er_d = 1'b1;
                end
                if (acertos_prox == total_q) begin
                    estado_d = FIM;
                    vit_d    = 1'b1;
                end else if (tiros_prox == MAX_T) begin
                    estado_d = FIM;
                    der_d    = 1'b1;
                end else begin
                    estado_d = AGUARDA;
                end
            end
            FIM: begin
            end
            default: estado_d = OCIOSO;
        endcase

        // Leaving attack mode aborts the round, discarding any shot in evaluation.
        if (!modo_ataque && estado_q != OCIOSO) begin
            estado_d  = OCIOSO;
            ating_d   = '0;
            err_d     = '0;
            acertos_d = '0;
            tiros_d   = '0;
            led_ac_d  = 1'b0;
            led_er_d  = 1'b0;
            vit_d     = 1'b0;
            der_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= OCIOSO;
            mapa_q    <= '0;
            total_q   <= '0;
            idx_q     <= '0;
            disparo_q <= 1'b0;
            ating_q   <= '0;
            err_q     <= '0;
            acertos_q <= '0;
            tiros_q   <= '0;
            led_ac_q  <= 1'b0;
            led_er_q  <= 1'b0;
            vit_q     <= 1'b0;
            der_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            mapa_q    <= mapa_d;
            total_q   <= total_d;
            idx_q     <= idx_d;
            disparo_q <= disparo;
            ating_q   <= ating_d;
            err_q     <= err_d;
            acertos_q <= acertos_d;
            tiros_q   <= tiros_d;
            led_ac_q  <= led_ac_d;
            led_er_q  <= led_er_d;
            vit_q     <= vit_d;
            der_q     <= der_d;
        end
    end

    assign celulas_atingidas = ating_q;
    assign celulas_erradas   = err_q;
    assign acertos           = acertos_q;
    assign tiros             = tiros_q;
    assign led_acerto        = led_ac_q;
    assign led_erro          = led_er_q;
    assign vitoria           = vit_q;
    assign derrota           = der_q;
    assign estado            = estado_q;

endmodule

// File: tb/tb_controlador_ataque.sv
// Bench for controlador_ataque: two instances (10 and 3 shots) driven with the same
// stimulus and compared every cycle against a round-level reference model.
module tb_controlador_ataque;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        modo = 1'b0;
    logic        disparo = 1'b0;
    logic [2:0]  linha = 3'd0;
    logic [2:0]  coluna = 3'd0;
    logic [34:0] mapa = '0;

    logic [34:0] at [2];
    logic [34:0] er [2];
    logic [5:0]  ac [2];
    logic [5:0]  ti [2];
    logic        la [2];
    logic        le [2];
    logic        vi [2];
    logic        de [2];
    logic [1:0]  es [2];

    int n_checks = 0;
    int n_erros  = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    controlador_ataque #(.MAX_TIROS(10)) dut10 (
        .clk(clk), .rst(rst), .modo_ataque(modo), .disparo(disparo),
        .coord_linha(linha), .coord_coluna(coluna), .mapa(mapa),
        .celulas_atingidas(at[0]), .celulas_erradas(er[0]), .acertos(ac[0]), .tiros(ti[0]),
        .led_acerto(la[0]), .led_erro(le[0]), .vitoria(vi[0]), .derrota(de[0]), .estado(es[0])
    );

    controlador_ataque #(.MAX_TIROS(3)) dut3 (
        .clk(clk), .rst(rst), .modo_ataque(modo), .disparo(disparo),
        .coord_linha(linha), .coord_coluna(coluna), .mapa(mapa),
        .celulas_atingidas(at[1]), .celulas_erradas(er[1]), .acertos(ac[1]), .tiros(ti[1]),
        .led_acerto(la[1]), .led_erro(le[1]), .vitoria(vi[1]), .derrota(de[1]), .estado(es[1])
    );

    // Reference model: a round is active or not, may hold one pending shot, may be over.
    bit [34:0] m_mapa [2];
    bit [34:0] m_hit  [2];
    bit [34:0] m_miss [2];
    int        m_total [2];
    int        m_ac [2];
    int        m_ti [2];
    bit        m_la [2];
    bit        m_le [2];
    bit        m_vi [2];
    bit        m_de [2];
    bit        m_ativo [2];
    bit        m_term [2];
    int        m_pend [2] = '{-1, -1};
    bit        disp_prev = 1'b0;
    bit        fire_ev;

    task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_erros++;
            $display("FAIL %s: obtido %0h esperado %0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    task automatic limpa(input int k);
        m_hit[k] = '0; m_miss[k] = '0; m_ac[k] = 0; m_ti[k] = 0;
        m_la[k] = 0; m_le[k] = 0; m_vi[k] = 0; m_de[k] = 0;
        m_pend[k] = -1; m_term[k] = 0;
    endtask

    function automatic int m_estado(input int k);
        if (!m_ativo[k]) return 0;
        if (m_pend[k] >= 0) return 2;
        if (m_term[k]) return 3;
        return 1;
    endfunction

    task automatic modelo_passo(input int k, input int maxt, input bit fire);
        int ix;
        if (!m_ativo[k]) begin
            if (modo) begin
                limpa(k);
                m_ativo[k] = 1;
                m_mapa[k]  = mapa;
                m_total[k] = $countones(mapa);
            end
        end else if (!modo) begin
            limpa(k);
            m_ativo[k] = 0;
        end else if (m_pend[k] >= 0) begin
            ix = m_pend[k];
            m_pend[k] = -1;
            m_ti[k]++;
            if (m_mapa[k][ix]) begin
                m_hit[k][ix] = 1; m_ac[k]++; m_la[k] = 1; m_le[k] = 0;
            end else begin
                m_miss[k][ix] = 1; m_la[k] = 0; m_le[k] = 1;
            end
            if (m_ac[k] == m_total[k]) begin
                m_term[k] = 1; m_vi[k] = 1;
            end else if (m_ti[k] == maxt) begin
                m_term[k] = 1; m_de[k] = 1;
            end
        end else if (!m_term[k]) begin
            if (m_total[k] == 0) begin
                m_term[k] = 1; m_vi[k] = 1;
            end else if (fire && linha <= 6 && coluna <= 4) begin
                ix = linha * 5 + coluna;
                if (!m_hit[k][ix] && !m_miss[k][ix]) m_pend[k] = ix;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                limpa(k);
                m_ativo[k] = 0;
            end
            disp_prev = 0;
        end else begin
            fire_ev   = disparo && !disp_prev;
            disp_prev = disparo;
            modelo_passo(0, 10, fire_ev);
            modelo_passo(1, 3, fire_ev);
        end
    end

    task automatic compara_todos();
        for (int k = 0; k < 2; k++) begin
            verifica($sformatf("m%0d estado", k), es[k], m_estado(k));
            verifica($sformatf("m%0d atingidas", k), at[k], m_hit[k]);
            verifica($sformatf("m%0d erradas", k), er[k], m_miss[k]);
            verifica($sformatf("m%0d acertos", k), ac[k], m_ac[k]);
            verifica($sformatf("m%0d tiros", k), ti[k], m_ti[k]);
            verifica($sformatf("m%0d leds", k), {la[k], le[k]}, {m_la[k], m_le[k]});
            verifica($sformatf("m%0d vit_der", k), {vi[k], de[k]}, {m_vi[k], m_de[k]});
        end
    endtask

    always @(negedge clk) if (chk_en) compara_todos();

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic fire(input int l, input int c);
        linha = 3'(l); coluna = 3'(c); disparo = 1'b1;
        tick(1);
        disparo = 1'b0;
        tick(1);
    endtask

    initial begin
        #1;
        verifica("rst estado", es[0], 0);
        verifica("rst saidas", {at[0], er[0], ac[0], ti[0], la[0], le[0], vi[0], de[0]}, 0);
        chk_en = 1'b1;
        #22 rst = 1'b0;
        tick(1);
        verifica("pos rst estado", es[0], 0);

        // first hit
        modo = 1'b1; mapa = 35'h81;
        tick(1);
        verifica("entrada estado", es[0], 1);
        fire(0, 0);
        verifica("hit atingidas", at[0], 35'h1);
        verifica("hit acertos", ac[0], 1);
        verifica("hit tiros", ti[0], 1);
        verifica("hit led", {la[0], le[0]}, 2'b10);
        verifica("hit estado", es[0], 1);

        // miss with mapa changed mid-round (must stay frozen), repeat and illegal coord
        mapa = 35'h7_FFFF_FFFF;
        fire(0, 1);
        verifica("miss erradas", er[0], 35'h2);
        verifica("miss led", {la[0], le[0]}, 2'b01);
        verifica("miss tiros", ti[0], 2);
        fire(0, 1);
        verifica("repete tiros", ti[0], 2);
        fire(7, 0);
        verifica("ilegal tiros", ti[0], 2);
        verifica("ilegal estado", es[0], 1);

        // win; dut3 reaches its budget on the same shot, victory has priority
        fire(1, 2);
        verifica("vit acertos", ac[0], 2);
        verifica("vit flags", {vi[0], de[0]}, 2'b10);
        verifica("vit estado", es[0], 3);
        verifica("vit prioridade m3", {vi[1], de[1], ti[1]}, {2'b10, 6'd3});
        fire(2, 2);
        verifica("fim congela tiros", ti[0], 3);
        verifica("fim congela estado", es[0], 3);
        modo = 1'b0;
        tick(1);
        verifica("saida estado", es[0], 0);
        verifica("saida zeros", {at[0], er[0], ac[0], ti[0], la[0], le[0], vi[0], de[0]}, 0);

        // loss on the 3-shot instance
        mapa = 35'h1; modo = 1'b1;
        tick(1);
        fire(0, 1); fire(0, 2); fire(0, 3);
        verifica("derrota tiros", ti[1], 3);
        verifica("derrota flags", {vi[1], de[1]}, 2'b01);
        verifica("derrota estado", es[1], 3);

        // button held high for 50 cycles yields one shot
        modo = 1'b0; tick(1);
        modo = 1'b1; tick(1);
        linha = 3'd1; coluna = 3'd1; disparo = 1'b1;
        tick(50);
        disparo = 1'b0;
        tick(1);
        verifica("segurado tiros", ti[0], 1);
        verifica("segurado erradas", er[0], 35'h40);

        // reset during evaluation clears at once
        linha = 3'd2; coluna = 3'd0; disparo = 1'b1;
        tick(1);
        verifica("avalia estado", es[0], 2);
        #1 rst = 1'b1;
        #1;
        verifica("rst avalia estado", es[0], 0);
        verifica("rst avalia zeros", {at[0], er[0], ac[0], ti[0]}, 0);
        disparo = 1'b0; modo = 1'b0;
        #3 rst = 1'b0;
        tick(1);

        // empty map wins two edges after entry
        mapa = '0; modo = 1'b1;
        tick(1);
        verifica("vazio entrada", {es[0], vi[0]}, {2'd1, 1'b0});
        tick(1);
        verifica("vazio vitoria", {es[0], vi[0]}, {2'd3, 1'b1});

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            rst     = ($urandom_range(0, 199) == 0);
            modo    = ($urandom_range(0, 99) >= 3);
            disparo = $urandom_range(0, 1) == 1;
            linha   = 3'($urandom_range(0, 7));
            coluna  = 3'($urandom_range(0, 7));
            mapa    = {3'($urandom), 32'($urandom & $urandom & $urandom)};
        end
        @(posedge clk); #2 rst = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_erros);
        $finish;
    end

endmodule

// File: doc/controlador_ataque.md
CONTROLADOR_ATAQUE -- requirements
Module: controlador_ataque

Interface
REQ-001 The block SHALL take parameter MAX_TIROS, default 10, meaning the shot budget per round (legal range 1..35).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- modo_ataque  input  1  level; 1 = attack mode selected.
- disparo  input  1  debounced fire button, active-high level.
- coord_linha  input  3  target row, legal values 0..6.
- coord_coluna  input  3  target column, legal values 0..4.
- mapa  input  35  enemy map; bit index = linha*5+coluna.
- celulas_atingidas  output  35  hit mask, same bit order as mapa.
- celulas_erradas  output  35  miss mask, same bit order as mapa.
- acertos  output  6  hit count.
- tiros  output  6  shots-consumed count.
- led_acerto  output  1  last shot was a hit.
- led_erro  output  1  last shot was a miss.
- vitoria  output  1  round won.
- derrota  output  1  round lost.
- estado  output  2  FSM state code.

Function
REQ-003 The FSM SHALL have four states: OCIOSO=0, AGUARDA=1, AVALIA=2, FIM=3; the estado output SHALL carry the current code.
REQ-004 OCIOSO with modo_ataque=1 SHALL go to AGUARDA on the next edge, with the following actions on that edge.
- Capture mapa into mapa_reg.
- Load total = popcount(mapa).
- Clear both masks, both counters and all four flags.
REQ-005 The register mapa_reg SHALL stay frozen for the round; later changes on mapa SHALL have no effect until the next entry from OCIOSO.
REQ-006 A fire event SHALL be defined as disparo=1 sampled while the registered disparo was 0. Holding disparo high SHALL produce exactly one event.
REQ-007 In AGUARDA, a fire event SHALL be accepted only if all three conditions hold; otherwise it is ignored, with no state change and no shot consumed.
- coord_linha <= 6.
- coord_coluna <= 4.
- The target cell is not already set in celulas_atingidas or celulas_erradas.
REQ-008 On the accepting edge N, the block SHALL latch idx = coord_linha*5+coord_coluna and enter AVALIA.
REQ-009 On edge N+1, in AVALIA, the block SHALL perform the following updates.
- tiros SHALL increment by 1.
- If mapa_reg[idx]=1: set celulas_atingidas[idx], increment acertos, drive led_acerto=1 and led_erro=0.
- Otherwise: set celulas_erradas[idx], drive led_erro=1 and led_acerto=0.
REQ-010 The hit/miss response SHALL be visible two edges after the button edge is sampled.
REQ-011 After AVALIA, the next state SHALL be chosen in this priority order.
- FIM with vitoria=1, if the new acertos equals total.
- Else FIM with derrota=1, if the new tiros equals MAX_TIROS.
- Else AGUARDA.
- vitoria and derrota SHALL never both be 1.
REQ-012 In AGUARDA with total=0, the FSM SHALL go to FIM with vitoria=1 on the next edge.
REQ-013 Fire events SHALL be ignored in AVALIA and FIM.
REQ-014 In FIM, all outputs SHALL hold until modo_ataque=0.
REQ-015 modo_ataque=0 in any state other than OCIOSO SHALL, on the next edge, force OCIOSO and clear all outputs to 0, including an in-flight AVALIA; the pending shot is discarded.
REQ-016 Counters SHALL never wrap: acertos <= total <= 35 and tiros <= MAX_TIROS are guaranteed by the FSM.
REQ-017 led_acerto and led_erro SHALL be mutually exclusive, and both SHALL be 0 until the first evaluated shot of a round.

Reset
REQ-018 rst=1 SHALL immediately, without waiting for clk, produce the following values.
- estado=OCIOSO.
- All outputs 0.
- mapa_reg, total, idx and the registered disparo cleared.
REQ-019 Reset SHALL override every other input, including mid-AVALIA.
REQ-020 After rst falls, the first transition SHALL occur on the next clk edge, per REQ-004.

Verification
REQ-021 The bench SHALL cover at least the following scenarios with MAX_TIROS=10 unless stated.
- Reset: assert rst, then release -> all outputs 0, estado=0.
- First hit: modo_ataque=1, mapa=35'h81, fire at (0,0) -> two edges later celulas_atingidas=35'h1, acertos=1, tiros=1, led_acerto=1, estado=1.
- Miss and repeat: then fire (0,1) -> celulas_erradas=35'h2, led_erro=1, tiros=2. Fire (0,1) again -> ignored, tiros stays 2. Fire (7,0) -> ignored.
- Win: then fire (1,2) (idx 7) -> acertos=2, vitoria=1, estado=3. Further fire pulses -> no change. modo_ataque=0 -> estado=0, all outputs 0.
- Loss: MAX_TIROS=3, mapa=35'h1, fire (0,1),(0,2),(0,3) -> tiros=3, derrota=1, vitoria=0. Also disparo held high for 50 cycles -> exactly one shot.
- Edge cases: rst during AVALIA -> masks and counters 0 immediately. mapa=0 on entry -> vitoria=1 two edges after modo_ataque rises.
